// File: rtl/life_pkg.sv
// life_pkg: shared constants and types for the Game of Life generation sequencer.
// Holds the board dimension, the sequencer state encoding, and the bit
// positions of each neighbour within the 8-bit sides vector.
package life_pkg;

  localparam int unsigned N  = 8;
  localparam int unsigned LW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_PUSH    = 2'd3
  } state_e;

  // Neighbour bit positions in sides[7:0] = {NW,N,NE,W,E,SW,S,SE}
  localparam int unsigned SIDE_NW = 7;
  localparam int unsigned SIDE_N  = 6;
  localparam int unsigned SIDE_NE = 5;
  localparam int unsigned SIDE_W  = 4;
  localparam int unsigned SIDE_E  = 3;
  localparam int unsigned SIDE_SW = 2;
  localparam int unsigned SIDE_S  = 1;
  localparam int unsigned SIDE_SE = 0;

endpackage

// File: rtl/life_cell_rule.sv
// life_cell_rule: combinational single-cell Game of Life rule.
// Ports:
//   center        in  current state of the cell
//   sides[7:0]    in  the eight neighbour states
//   next_alive_c  out cell state for the next generation
module life_cell_rule (
  input  logic       center,
  input  logic [7:0] sides,
  output logic       next_alive_c
);

  logic [3:0] count;

  // Birth on exactly three neighbours, survival on two or three.
  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + 4'(sides[i]);
    end
    next_alive_c = (count == 4'd3) || (center && (count == 4'd2));
  end

endmodule

// File: rtl/life_gen_sequencer.sv
// life_gen_sequencer: owns the current/next 8x8 board, evaluates one generation
// cell by cell with toroidal wrap, commits it, then streams the board to the
// LED display controller row by row.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   load_en/row/data    seed write of one row (IDLE only, mirrored to display)
//   step                one-cycle request for a single generation
//   run                 level enable for auto-stepping every PERIOD idle cycles
//   busy                generation or display push in progress
//   done                one-cycle pulse on return to IDLE after a generation
//   gen_count           committed generations, wraps modulo 2^GCW
//   disp_we/addr/row    registered display row write port
module life_gen_sequencer #(
  parameter int unsigned N      = 8,
  parameter int unsigned PERIOD = 1000000,
  parameter int unsigned GCW    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [$clog2(N)-1:0]  load_row,
  input  logic [N-1:0]          load_data,
  input  logic                  step,
  input  logic                  run,
  output logic                  busy,
  output logic                  done,
  output logic [GCW-1:0]        gen_count,
  output logic                  disp_we,
  output logic [$clog2(N)-1:0]  disp_addr,
  output logic [N-1:0]          disp_row
);

  import life_pkg::*;

  localparam int unsigned RW  = $clog2(N);
  localparam int unsigned KW  = 2 * RW;
  localparam int unsigned ICW = $clog2(PERIOD);

  typedef logic [N-1:0][N-1:0] board_t;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [ICW-1:0] idle_q, idle_d;
  board_t         cur_q, cur_d;
  board_t         nxt_q, nxt_d;
  logic [GCW-1:0] gen_q, gen_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dwe_q, dwe_d;
  logic [RW-1:0]  daddr_q, daddr_d;
  logic [N-1:0]   drow_q, drow_d;

  logic [RW-1:0]  r, c, rm, rp, cm, cp;
  logic           center;
  logic [7:0]     sides;
  logic           next_alive_c;

  // Neighbour gather for cell k; N is a power of two so index wrap is free.
  always_comb begin
    r      = k_q[KW-1:RW];
    c      = k_q[RW-1:0];
    rm     = r - RW'(1);
    rp     = r + RW'(1);
    cm     = c - RW'(1);
    cp     = c + RW'(1);
    center = cur_q[r][c];
    sides          = '0;
    sides[SIDE_NW] = cur_q[rm][cm];
    sides[SIDE_N]  = cur_q[rm][c];
    sides[SIDE_NE] = cur_q[rm][cp];
    sides[SIDE_W]  = cur_q[r][cm];
    sides[SIDE_E]  = cur_q[r][cp];
    sides[SIDE_SW] = cur_q[rp][cm];
    sides[SIDE_S]  = cur_q[rp][c];
    sides[SIDE_SE] = cur_q[rp][cp];
  end

  life_cell_rule u_rule (
    .center       (center),
    .sides        (sides),
    .next_alive_c (next_alive_c)
  );

  // Next-state, board update and display port logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    idle_d  = '0;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    gen_d   = gen_q;
    done_d  = 1'b0;
    dwe_d   = 1'b0;
    daddr_d = daddr_q;
    drow_d  = drow_q;

    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          cur_d[load_row] = load_data;
          dwe_d           = 1'b1;
          daddr_d         = load_row;
          drow_d          = load_data;
        end else if (step) begin
          state_d = ST_COMPUTE;
          k_d     = '0;
        end else if (run && (idle_q == ICW'(PERIOD - 1))) begin
          state_d = ST_COMPUTE;
          k_d     = '0;
        end else if (run && !done_q) begin
          // The done cycle closes the generation; the interval counts after it.
          idle_d = idle_q + ICW'(1);
        end
      end
      ST_COMPUTE: begin
        nxt_d[r][c] = next_alive_c;
        k_d         = k_q + KW'(1);
        if (k_q == {KW{1'b1}}) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        cur_d   = nxt_q;
        gen_d   = gen_q + GCW'(1);
        state_d = ST_PUSH;
        k_d     = '0;
      end
      ST_PUSH: begin
        k_d = k_q + KW'(1);
        if (k_q[RW-1:0] == RW'(N - 1)) begin
          state_d = ST_IDLE;
          k_d     = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered push so the write lines up with the PUSH cycle itself.
    if (state_d == ST_PUSH) begin
      dwe_d   = 1'b1;
      daddr_d = k_d[RW-1:0];
      drow_d  = cur_d[k_d[RW-1:0]];
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      idle_q  <= '0;
      cur_q   <= '0;
      nxt_q   <= '0;
      gen_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dwe_q   <= 1'b0;
      daddr_q <= '0;
      drow_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idle_q  <= idle_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      gen_q   <= gen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dwe_q   <= dwe_d;
      daddr_q <= daddr_d;
      drow_q  <= drow_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign gen_count = gen_q;
  assign disp_we   = dwe_q;
  assign disp_addr = daddr_q;
  assign disp_row  = drow_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// tb_life_gen_sequencer: self-checking bench for life_gen_sequencer.
// Expected display writes are queued from a reference Life model when the
// stimulus is driven and compared as the DUT emits them.
module tb_life_gen_sequencer;

  localparam int unsigned N      = 8;
  localparam int unsigned PERIOD = 4;
  localparam int unsigned GCW    = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            load_en = 1'b0;
  logic [2:0]      load_row = '0;
  logic [7:0]      load_data = '0;
  logic            step = 1'b0;
  logic            run = 1'b0;
  logic            busy;
  logic            done;
  logic [GCW-1:0]  gen_count;
  logic            disp_we;
  logic [2:0]      disp_addr;
  logic [7:0]      disp_row;

  always #5 clk = ~clk;

  life_gen_sequencer #(.N(N), .PERIOD(PERIOD), .GCW(GCW)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_row  (load_row),
    .load_data (load_data),
    .step      (step),
    .run       (run),
    .busy      (busy),
    .done      (done),
    .gen_count (gen_count),
    .disp_we   (disp_we),
    .disp_addr (disp_addr),
    .disp_row  (disp_row)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_seen = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  mb[8];
  logic [7:0]  dut_rows[8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Display monitor / scoreboard consumer.
  always @(posedge clk) begin
    logic [10:0] e;
    #1;
    if (done === 1'b1) done_seen++;
    if (disp_we === 1'b1) begin
      dut_rows[disp_addr] = disp_row;
      if (exp_q.size() == 0) begin
        check_eq("disp_unexpected_we", 32'(disp_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("disp_write", 32'({disp_addr, disp_row}), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 8; r++) mb[r] = 8'h00;
  endtask

  // Reference generation with toroidal wrap.
  task automatic model_step();
    logic [7:0] nb[8];
    int cnt;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0)) begin
              cnt += int'(mb[(r + dr + 8) % 8][(c + dc + 8) % 8]);
            end
          end
        end
        nb[r][c] = (cnt == 3) || (mb[r][c] && cnt == 2);
      end
    end
    for (int r = 0; r < 8; r++) mb[r] = nb[r];
  endtask

  task automatic push_board();
    for (int r = 0; r < 8; r++) exp_q.push_back({3'(r), mb[r]});
  endtask

  task automatic do_reset();
    reset = 1'b1; load_en = 1'b0; step = 1'b0; run = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    model_clear();
  endtask

  task automatic load(input logic [2:0] row, input logic [7:0] data);
    load_en = 1'b1; load_row = row; load_data = data;
    mb[row] = data;
    exp_q.push_back({row, data});
    tick();
    load_en = 1'b0;
  endtask

  // One generation from a step; optional stray step/load while busy.
  task automatic gen_step(input int step_at, input int load_at, output int lat, output bit gap);
    step = 1'b1;
    model_step();
    push_board();
    tick();
    step = 1'b0;
    lat = 1;
    gap = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) gap = 1'b1;
      step    = (lat == step_at);
      load_en = (lat == load_at);
      load_row  = 3'd5;
      load_data = 8'hFF;
      tick();
      lat++;
    end
    step = 1'b0;
    load_en = 1'b0;
  endtask

  initial begin
    int lat;
    bit gap;
    int d0;
    int n;
    int busy_cnt;

    // Reset state
    do_reset();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_gen_count", 32'(gen_count), 32'd0);
    check_eq("rst_disp_we", 32'(disp_we), 32'd0);
    check_eq("rst_disp_addr", 32'(disp_addr), 32'd0);
    check_eq("rst_disp_row", 32'(disp_row), 32'd0);

    // Blinker
    load(3'd3, 8'b00011100);
    gen_step(-1, -1, lat, gap);
    check_eq("blink_latency", 32'(lat), 32'd74);
    check_eq("blink_busy_gap", 32'(gap), 32'd0);
    check_eq("blink_busy_end", 32'(busy), 32'd0);
    check_eq("blink_gen_count", 32'(gen_count), 32'd1);
    check_eq("blink_row2", 32'(dut_rows[2]), 32'h08);
    check_eq("blink_row3", 32'(dut_rows[3]), 32'h08);
    check_eq("blink_row4", 32'(dut_rows[4]), 32'h08);
    check_eq("blink_row0", 32'(dut_rows[0]), 32'h00);
    tick();
    check_eq("blink_done_pulse", 32'(done), 32'd0);
    check_eq("blink_we_idle", 32'(disp_we), 32'd0);
    check_eq("blink_queue", 32'(exp_q.size()), 32'd0);

    // Wrap
    do_reset();
    load(3'd0, 8'b10000011);
    gen_step(-1, -1, lat, gap);
    check_eq("wrap_row7", 32'(dut_rows[7]), 32'h01);
    check_eq("wrap_row0", 32'(dut_rows[0]), 32'h01);
    check_eq("wrap_row1", 32'(dut_rows[1]), 32'h01);
    check_eq("wrap_row2", 32'(dut_rows[2]), 32'h00);
    // Back-to-back step in the done cycle
    gen_step(-1, -1, lat, gap);
    check_eq("wrap_latency2", 32'(lat), 32'd74);
    check_eq("wrap_restore_row0", 32'(dut_rows[0]), 32'h83);
    check_eq("wrap_gen_count", 32'(gen_count), 32'd2);

    // Still life
    do_reset();
    load(3'd3, 8'b00011000);
    load(3'd4, 8'b00011000);
    for (int i = 0; i < 3; i++) gen_step(-1, -1, lat, gap);
    check_eq("still_gen_count", 32'(gen_count), 32'd3);
    check_eq("still_row3", 32'(dut_rows[3]), 32'h18);
    check_eq("still_row4", 32'(dut_rows[4]), 32'h18);

    // Ignored step and load while busy
    do_reset();
    load(3'd3, 8'b00011100);
    d0 = done_seen;
    gen_step(9, 20, lat, gap);
    repeat (20) tick();
    check_eq("ign_one_done", 32'(done_seen - d0), 32'd1);
    check_eq("ign_idle", 32'(busy), 32'd0);
    gen_step(-1, -1, lat, gap);
    check_eq("ign_row3", 32'(dut_rows[3]), 32'h1C);
    check_eq("ign_row5", 32'(dut_rows[5]), 32'h00);

    // Load with step in IDLE: load wins, no generation
    load_en = 1'b1; step = 1'b1; load_row = 3'd0; load_data = 8'h01;
    mb[0] = 8'h01;
    exp_q.push_back({3'd0, 8'h01});
    tick();
    load_en = 1'b0; step = 1'b0;
    d0 = done_seen;
    busy_cnt = 0;
    repeat (100) begin
      tick();
      if (busy === 1'b1) busy_cnt++;
    end
    check_eq("ldstep_no_busy", 32'(busy_cnt), 32'd0);
    check_eq("ldstep_no_done", 32'(done_seen - d0), 32'd0);
    check_eq("ldstep_gen_count", 32'(gen_count), 32'd2);
    check_eq("ldstep_row0", 32'(dut_rows[0]), 32'h01);

    // Reset mid-COMPUTE
    do_reset();
    load(3'd3, 8'b00011100);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (29) tick();
    check_eq("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_gen_count", 32'(gen_count), 32'd0);
    check_eq("midrst_disp_we", 32'(disp_we), 32'd0);
    d0 = done_seen;
    repeat (80) tick();
    check_eq("midrst_no_done", 32'(done_seen - d0), 32'd0);
    gen_step(-1, -1, lat, gap);
    check_eq("midrst_row3", 32'(dut_rows[3]), 32'h00);
    check_eq("midrst_gen_count2", 32'(gen_count), 32'd1);

    // Run mode
    do_reset();
    load(3'd3, 8'b00011100);
    run = 1'b1;
    model_step();
    push_board();
    n = 0;
    do begin tick(); n++; end while (done !== 1'b1 && n < 400);
    check_eq("run_first_done", 32'(done), 32'd1);
    model_step();
    push_board();
    n = 0;
    do begin tick(); n++; end while (done !== 1'b1 && n < 400);
    check_eq("run_spacing", 32'(n), 32'd78);
    run = 1'b0;
    d0 = done_seen;
    busy_cnt = 0;
    repeat (300) begin
      tick();
      if (busy === 1'b1) busy_cnt++;
    end
    check_eq("run_stop_done", 32'(done_seen - d0), 32'd0);
    check_eq("run_stop_busy", 32'(busy_cnt), 32'd0);
    check_eq("run_gen_count", 32'(gen_count), 32'd2);
    check_eq("run_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/life_gen_sequencer.md
# life_gen_sequencer

Generation scheduler for the 8x8 Game of Life board. Owns the current and next board state, walks every cell through the single-cell rule once per generation with toroidal wrap-around, and commits the result. After each commit it streams the new board row by row to the LED display controller. It sits between user seeding/step controls and the display path.

## Interface

Parameters:
- N, 8: board dimension. Must be a power of 2; fixed at 8 for the LED matrix.
- PERIOD, 1000000: auto-run interval in clk cycles. Legal range is 2 or more.
- GCW, 16: width of gen_count.

Ports:
- clk  in  1  system clock. The block has one clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  seed-write strobe. Honoured only in IDLE.
- load_row  in  3  row index for the seed write.
- load_data  in  8  row bits. Bit c is column c; 1 means alive.
- step  in  1  single-cycle request for one generation.
- run  in  1  level signal that enables auto-stepping every PERIOD idle cycles.
- busy  out  1  high while a generation or display push is in progress.
- done  out  1  one-cycle pulse when a generation finishes.
- gen_count  out  GCW  number of committed generations. Wraps modulo 2^GCW.
- disp_we  out  1  display row write strobe.
- disp_addr  out  3  display row index.
- disp_row  out  8  display row data.

## Operation

- State: cur[N][N] and nxt[N][N] bit arrays; FSM states IDLE, COMPUTE, COMMIT, PUSH.
- IDLE, priority order:
  - load_en: cur[load_row] <= load_data. The same cycle mirrors the write to the display: disp_we=1, disp_addr=load_row, disp_row=load_data.
  - Otherwise step: go to COMPUTE.
  - Otherwise auto-run: if run=1 and the idle counter equals PERIOD-1, go to COMPUTE.
- Idle counter:
  - Increments in IDLE while run=1.
  - Clears when run=0, on any load, and on leaving IDLE.
  - A step or load arriving together with counter expiry wins; the counter clears.
- COMPUTE runs 64 cycles with cell index k=0..63 (r=k[5:3], c=k[2:0]).
  - center=cur[r][c].
  - sides={NW,N,NE,W,E,SW,S,SE} as bits [7:0]. Neighbour coordinates are taken mod N, so row 0 and row 7 are adjacent, and column 0 and column 7 are adjacent.
  - nxt[r][c] <= rule(center, sides).
  - Rule: alive next if the neighbour count is 3, or if center=1 and the count is 2.
- COMMIT runs 1 cycle: cur <= nxt; gen_count <= gen_count+1.
- PUSH runs 8 cycles with row r=0..7: disp_we=1, disp_addr=r, disp_row=cur[r].
- After PUSH: return to IDLE and pulse done for that one cycle.
- Inputs while busy: step, run expiry and load_en are ignored and not queued.

## Timing

- Reset values: FSM in IDLE; cur, nxt and idle counter cleared; busy=0, done=0, gen_count=0, disp_we=0, disp_addr=0, disp_row=0. The display contents are not cleared by this block.
- Generation timeline, with step sampled in IDLE at cycle t:
  - t+1..t+64: COMPUTE.
  - t+65: COMMIT.
  - t+66..t+73: PUSH.
  - t+74: IDLE with done=1.
- busy=1 for exactly cycles t+1..t+73.
- Back-to-back: step at t+74 starts the next generation, giving a 74-cycle cadence.
- Auto-run with run held high: the next generation starts PERIOD cycles after the done cycle.
- disp_* outputs are registered. Outside a load mirror or PUSH, disp_we=0.
- Reset mid-generation, in any state: next cycle is IDLE with the reset values. A partial nxt is discarded; no done pulse.
- gen_count wraps from 2^GCW-1 to 0 at COMMIT.

## Structure

- Package life_pkg holds:
  - N;
  - the state enum (IDLE, COMPUTE, COMMIT, PUSH);
  - localparams for side bit positions (SIDE_NW=7 through SIDE_SE=0).
- Sub-module life_cell_rule is the purely combinational (center, sides[7:0]) -> next_alive rule, instantiated once and time-multiplexed over the 64 cells.
- The neighbour gather is a combinational mux inside the top level. The FSM, counters and board registers live in the top level.

## Test plan

- Blinker: load row 3=8'b00011100, then step.
  - Rows 2, 3 and 4 become 8'b00001000; all other rows are 0.
  - PUSH writes addrs 0..7; done at t+74; gen_count=1.
- Wrap: load row 0=8'b10000011, then step.
  - Rows 7, 0 and 1 become 8'b00000001; all other rows are 0.
  - A second step restores row 0=8'b10000011.
- Still life: load rows 3 and 4=8'b00011000, then step 3 times. The board is unchanged and gen_count=3.
- Ignored inputs:
  - step at t+10 is ignored: exactly one done.
  - load_en while busy is ignored: cur is unchanged.
  - load_en together with step in IDLE: load applied, no generation.
- Reset at t+30 mid-COMPUTE: next cycle busy=0, all rows 0, gen_count=0, no done pulse.
- Run mode with PERIOD=4 and run held high: done pulses are spaced by exactly 74+4 cycles; dropping run stops further generations.
